i2s_rx: RTL and testbench

- Serial audio receiver: the receive end of the 16-bit left-justified I2S-style link the top level drives toward the on-board DAC.
- Oversamples external bclk/lrck/din in the clk32 domain and deserialises MSB-first words into parallel stereo samples.
- Presents each left/right pair with a one-cycle valid strobe.
- Used for line-in/ADC capture and as a loopback checker for the existing audio transmitter.

---
 rtl/i2s_rx.sv | 202 ++++++++++++++++++++
 tb/tb_i2s_rx.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/i2s_rx.sv
// i2s_rx: serial audio receiver for a 16-bit left-justified / Philips I2S link.
//
// The asynchronous bclk/lrck/din pins are oversampled in the clk32 domain. Each bclk
// falling edge is a sample event. MSB-first words are deserialised per channel slot,
// and each completed left/right pair is presented on audio_l/audio_r with a one-cycle
// valid strobe.
//
// Ports:
//   clk32      in   system clock
//   reset_n    in   asynchronous active-low reset
//   i2s_bclk   in   serial bit clock (asynchronous, <= clk32/8)
//   i2s_lrck   in   word select, 0 = left, 1 = right (asynchronous)
//   i2s_din    in   serial data, MSB first (asynchronous)
//   audio_l    out  last complete left sample
//   audio_r    out  last complete right sample
//   valid      out  one-cycle pulse when audio_l/audio_r update as a pair
//   active     out  high while bclk edges keep arriving within TIMEOUT cycles
//   frame_err  out  one-cycle pulse when a slot closes with fewer than WIDTH bits
module i2s_rx #(
    parameter int unsigned WIDTH   = 16,
    parameter int unsigned DELAY   = 0,
    parameter int unsigned TIMEOUT = 1023
) (
    input  logic             clk32,
    input  logic             reset_n,
    input  logic             i2s_bclk,
    input  logic             i2s_lrck,
    input  logic             i2s_din,
    output logic [WIDTH-1:0] audio_l,
    output logic [WIDTH-1:0] audio_r,
    output logic             valid,
    output logic             active,
    output logic             frame_err
);

    localparam int unsigned   CW       = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] FULL     = CW'(WIDTH);
    localparam logic [9:0]    IDLE_MAX = 10'(TIMEOUT);

    // Synchronisers: [1] is the synchronised value, bclk_q[2] the delayed copy.
    logic [2:0]       bclk_q;
    logic [1:0]       lrck_q;
    logic [1:0]       din_q;

    logic             prev_lrck_q, prev_lrck_d;
    logic             seen_q,      seen_d;    // an event has occurred since reset/idle
    logic             locked_q,    locked_d;  // a slot boundary has occurred since reset/idle
    logic [CW-1:0]    bitcnt_q,    bitcnt_d;
    logic [WIDTH-1:0] shift_q,     shift_d;
    logic [WIDTH-1:0] hold_l_q,    hold_l_d;
    logic             hold_vld_q,  hold_vld_d;
    logic [WIDTH-1:0] audio_l_q,   audio_l_d;
    logic [WIDTH-1:0] audio_r_q,   audio_r_d;
    logic             valid_q,     valid_d;
    logic             err_pend_q,  err_pend_d;
    logic             frame_err_q;
    logic             active_q,    active_d;
    logic [9:0]       idle_q,      idle_d;

    logic             sample_ev;
    logic             boundary;
    logic             lrck_s;
    logic             din_s;
    logic [WIDTH-1:0] sh_word;
    logic [CW-1:0]    sh_cnt;
    logic [WIDTH-1:0] cl_word;
    logic [CW-1:0]    cl_cnt;
    logic [WIDTH-1:0] aligned;

    assign lrck_s    = lrck_q[1];
    assign din_s     = din_q[1];
    assign sample_ev = !bclk_q[1] && bclk_q[2];
    // The first event after reset/idle only records the channel, so that a stream
    // picked up mid-slot cannot fake a boundary.
    assign boundary  = sample_ev && seen_q && (lrck_s != prev_lrck_q);

    always_comb begin
        prev_lrck_d = prev_lrck_q;
        seen_d      = seen_q;
        locked_d    = locked_q;
        bitcnt_d    = bitcnt_q;
        shift_d     = shift_q;
        hold_l_d    = hold_l_q;
        hold_vld_d  = hold_vld_q;
        audio_l_d   = audio_l_q;
        audio_r_d   = audio_r_q;
        valid_d     = 1'b0;
        err_pend_d  = 1'b0;
        active_d    = active_q;
        idle_d      = idle_q;
        sh_word     = shift_q;
        sh_cnt      = bitcnt_q;
        cl_word     = '0;
        cl_cnt      = '0;
        aligned     = '0;

        // In-slot shift; bits past WIDTH are dropped. Nothing is counted until the
        // first boundary, which discards the partial slot.
        if (locked_q && (bitcnt_q < FULL)) begin
            sh_word = {shift_q[WIDTH-2:0], din_s};
            sh_cnt  = bitcnt_q + CW'(1);
        end

        if (sample_ev) begin
            idle_d      = '0;
            active_d    = 1'b1;
            seen_d      = 1'b1;
            prev_lrck_d = lrck_s;
            if (boundary) begin
                locked_d = 1'b1;
                if (DELAY != 0) begin
                    // Philips: this bit still belongs to the old channel.
                    cl_word  = sh_word;
                    cl_cnt   = sh_cnt;
                    shift_d  = '0;
                    bitcnt_d = '0;
                end else begin
                    // Left-justified: this bit is the MSB of the new channel.
                    cl_word  = shift_q;
                    cl_cnt   = bitcnt_q;
                    shift_d  = {{(WIDTH-1){1'b0}}, din_s};
                    bitcnt_d = CW'(1);
                end
                aligned = cl_word << (FULL - cl_cnt);
                if (cl_cnt != '0) begin
                    if (cl_cnt != FULL) begin
                        err_pend_d = 1'b1;
                    end
                    if (!prev_lrck_q) begin
                        hold_l_d   = aligned;
                        hold_vld_d = 1'b1;
                    end else if (hold_vld_q) begin
                        audio_l_d  = hold_l_q;
                        audio_r_d  = aligned;
                        valid_d    = 1'b1;
                        hold_vld_d = 1'b0;
                    end
                end
            end else begin
                shift_d  = sh_word;
                bitcnt_d = sh_cnt;
            end
        end else if (idle_q != IDLE_MAX) begin
            idle_d = idle_q + 10'd1;
        end else begin
            // Link idle: forget everything about the current frame.
            active_d   = 1'b0;
            bitcnt_d   = '0;
            shift_d    = '0;
            hold_vld_d = 1'b0;
            locked_d   = 1'b0;
            seen_d     = 1'b0;
        end
    end

    always_ff @(posedge clk32 or negedge reset_n) begin
        if (!reset_n) begin
            bclk_q      <= '0;
            lrck_q      <= '0;
            din_q       <= '0;
            prev_lrck_q <= 1'b0;
            seen_q      <= 1'b0;
            locked_q    <= 1'b0;
            bitcnt_q    <= '0;
            shift_q     <= '0;
            hold_l_q    <= '0;
            hold_vld_q  <= 1'b0;
            audio_l_q   <= '0;
            audio_r_q   <= '0;
            valid_q     <= 1'b0;
            err_pend_q  <= 1'b0;
            frame_err_q <= 1'b0;
            active_q    <= 1'b0;
            idle_q      <= '0;
        end else begin
            bclk_q      <= {bclk_q[1:0], i2s_bclk};
            lrck_q      <= {lrck_q[0], i2s_lrck};
            din_q       <= {din_q[0], i2s_din};
            prev_lrck_q <= prev_lrck_d;
            seen_q      <= seen_d;
            locked_q    <= locked_d;
            bitcnt_q    <= bitcnt_d;
            shift_q     <= shift_d;
            hold_l_q    <= hold_l_d;
            hold_vld_q  <= hold_vld_d;
            audio_l_q   <= audio_l_d;
            audio_r_q   <= audio_r_d;
            valid_q     <= valid_d;
            err_pend_q  <= err_pend_d;
            frame_err_q <= err_pend_q;
            active_q    <= active_d;
            idle_q      <= idle_d;
        end
    end

    assign audio_l   = audio_l_q;
    assign audio_r   = audio_r_q;
    assign valid     = valid_q;
    assign active    = active_q;
    assign frame_err = frame_err_q;

endmodule

// File: tb/tb_i2s_rx.sv
// tb_i2s_rx: directed bench for i2s_rx. Two instances share the same pins, one
// left-justified (DELAY=0) and one Philips (DELAY=1). Valid and frame_err pulses
// are counted on the falling clock edge.
`timescale 1ns/1ps
module tb_i2s_rx;

    localparam int unsigned H = 10; // clk32 cycles per bclk half period

    logic        clk32   = 1'b0;
    logic        reset_n = 1'b0;
    logic        bclk    = 1'b0;
    logic        lrck    = 1'b0;
    logic        din     = 1'b0;

    logic [15:0] l0, r0, l1, r1;
    logic        v0, a0, e0, v1, a1, e1;

    int n_checks = 0;
    int n_errors = 0;
    int nval0 = 0, nval1 = 0, nerr0 = 0, nerr1 = 0;

    always #5 clk32 = ~clk32;

    i2s_rx #(.WIDTH(16), .DELAY(0), .TIMEOUT(1023)) u_dut0 (
        .clk32    (clk32),
        .reset_n  (reset_n),
        .i2s_bclk (bclk),
        .i2s_lrck (lrck),
        .i2s_din  (din),
        .audio_l  (l0),
        .audio_r  (r0),
        .valid    (v0),
        .active   (a0),
        .frame_err(e0)
    );

    i2s_rx #(.WIDTH(16), .DELAY(1), .TIMEOUT(1023)) u_dut1 (
        .clk32    (clk32),
        .reset_n  (reset_n),
        .i2s_bclk (bclk),
        .i2s_lrck (lrck),
        .i2s_din  (din),
        .audio_l  (l1),
        .audio_r  (r1),
        .valid    (v1),
        .active   (a1),
        .frame_err(e1)
    );

    always @(negedge clk32) begin
        if (v0) nval0++;
        if (v1) nval1++;
        if (e0) nerr0++;
        if (e1) nerr1++;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Data changes with bclk rising; the receiver samples on bclk falling.
    task automatic send_bit(input logic lr, input logic d);
        bclk = 1'b1;
        lrck = lr;
        din  = d;
        repeat (H) @(negedge clk32);
        bclk = 1'b0;
        repeat (H) @(negedge clk32);
    endtask

    // Philips framing moves the lrck edge one bit ahead of the MSB.
    task automatic send_frame(input logic [31:0] l, input int ln,
                              input logic [31:0] r, input int rn, input bit phil);
        int   total;
        int   j;
        logic b;
        total = ln + rn;
        for (int i = 0; i < total; i++) begin
            j = phil ? (i + 1) % total : i;
            b = (i < ln) ? l[ln-1-i] : r[total-1-i];
            send_bit(j >= ln, b);
        end
    endtask

    task automatic send_frames(input logic [31:0] l, input int ln, input logic [31:0] r,
                               input int rn, input bit phil, input int n);
        for (int k = 0; k < n; k++) send_frame(l, ln, r, rn, phil);
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        bclk    = 1'b0;
        lrck    = 1'b0;
        din     = 1'b0;
        repeat (4) @(negedge clk32);
        reset_n = 1'b1;
        repeat (4) @(negedge clk32);
    endtask

    initial begin
        int b0, b1, eb0, eb1;

        repeat (3) @(negedge clk32);
        check("reset audio_l", 32'(l0), 32'h0);
        check("reset audio_r", 32'(r0), 32'h0);
        check("reset valid", 32'(v0), 32'h0);
        check("reset active", 32'(a0), 32'h0);
        check("reset frame_err", 32'(e0), 32'h0);
        reset_n = 1'b1;
        repeat (4) @(negedge clk32);

        // Left-justified stream; trailing bit closes the last right slot.
        b0 = nval0; eb0 = nerr0;
        send_frames(32'h8001, 16, 32'h7FFE, 16, 1'b0, 4);
        send_bit(1'b0, 1'b0);
        repeat (5) @(negedge clk32);
        check("lj valid count", 32'(nval0 - b0), 32'd3);
        check("lj audio_l", 32'(l0), 32'h8001);
        check("lj audio_r", 32'(r0), 32'h7FFE);
        check("lj frame_err", 32'(nerr0 - eb0), 32'd0);
        check("lj active", 32'(a0), 32'h1);

        // Philips stream: DELAY=1 decodes it, DELAY=0 is off by one bit.
        do_reset();
        b0 = nval0; b1 = nval1; eb1 = nerr1;
        send_frames(32'hA5C3, 16, 32'h0F0F, 16, 1'b1, 4);
        send_bit(1'b0, 1'b0);
        repeat (5) @(negedge clk32);
        check("phil d1 valid count", 32'(nval1 - b1), 32'd3);
        check("phil d1 audio_l", 32'(l1), 32'hA5C3);
        check("phil d1 audio_r", 32'(r1), 32'h0F0F);
        check("phil d1 frame_err", 32'(nerr1 - eb1), 32'd0);
        check("phil d0 valid count", 32'(nval0 - b0), 32'd3);
        check("phil d0 audio_l", 32'(l0), 32'hD2E1);
        check("phil d0 audio_r", 32'(r0), 32'h8787);

        // 32-bit slots with 24-bit data: only the top 16 bits are kept.
        do_reset();
        b0 = nval0; b1 = nval1; eb0 = nerr0; eb1 = nerr1;
        send_frames(32'h12345600, 32, 32'h12345600, 32, 1'b0, 4);
        send_bit(1'b0, 1'b0);
        repeat (5) @(negedge clk32);
        check("w32 valid count", 32'(nval0 - b0), 32'd3);
        check("w32 audio_l", 32'(l0), 32'h1234);
        check("w32 audio_r", 32'(r0), 32'h1234);
        check("w32 frame_err", 32'(nerr0 - eb0), 32'd0);
        check("w32 d1 valid count", 32'(nval1 - b1), 32'd3);
        check("w32 d1 audio_l", 32'(l1), 32'h2468);
        check("w32 d1 frame_err", 32'(nerr1 - eb1), 32'd0);

        // Short 12-bit right slot in the last frame.
        do_reset();
        b0 = nval0; eb0 = nerr0;
        send_frames(32'h1111, 16, 32'h2222, 16, 1'b0, 2);
        send_frame(32'h1111, 16, 32'hABC, 12, 1'b0);
        send_bit(1'b0, 1'b0);
        repeat (5) @(negedge clk32);
        check("short valid count", 32'(nval0 - b0), 32'd2);
        check("short audio_l", 32'(l0), 32'h1111);
        check("short audio_r", 32'(r0), 32'hABC0);
        check("short frame_err count", 32'(nerr0 - eb0), 32'd1);

        // Idle timeout, then restart mid-slot.
        check("idle active before", 32'(a0), 32'h1);
        repeat (1000) @(negedge clk32);
        check("idle active at 1000", 32'(a0), 32'h1);
        repeat (100) @(negedge clk32);
        check("idle active at 1100", 32'(a0), 32'h0);
        b0 = nval0; eb0 = nerr0;
        for (int i = 0; i < 8; i++) send_bit(1'b1, 1'b1);
        send_frame(32'h1357, 16, 32'h2468, 16, 1'b0);
        check("restart no early valid", 32'(nval0 - b0), 32'd0);
        check("restart active", 32'(a0), 32'h1);
        send_bit(1'b0, 1'b0);
        repeat (5) @(negedge clk32);
        check("restart valid count", 32'(nval0 - b0), 32'd1);
        check("restart audio_l", 32'(l0), 32'h1357);
        check("restart audio_r", 32'(r0), 32'h2468);
        check("restart frame_err", 32'(nerr0 - eb0), 32'd0);

        // Reset in the middle of a right word.
        send_frame(32'h4444, 16, 32'h66, 8, 1'b0);
        reset_n = 1'b0;
        #1;
        check("midreset audio_l", 32'(l0), 32'h0);
        check("midreset audio_r", 32'(r0), 32'h0);
        check("midreset active", 32'(a0), 32'h0);
        check("midreset valid", 32'(v0), 32'h0);
        lrck = 1'b0;
        din  = 1'b0;
        repeat (4) @(negedge clk32);
        reset_n = 1'b1;
        repeat (4) @(negedge clk32);
        b0 = nval0;
        send_frames(32'h5555, 16, 32'h6666, 16, 1'b0, 2);
        check("postreset no early valid", 32'(nval0 - b0), 32'd0);
        send_bit(1'b0, 1'b0);
        repeat (5) @(negedge clk32);
        check("postreset valid count", 32'(nval0 - b0), 32'd1);
        check("postreset audio_l", 32'(l0), 32'h5555);
        check("postreset audio_r", 32'(r0), 32'h6666);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
